// File: rtl/max7219_receiver.sv
// SPI responder emulating the MAX7219 register interface: oversamples SCK/CS/MOSI with clk,
// decodes 16-bit frames on CS rise and exposes the resulting register file.
module max7219_receiver #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       res,
    input  logic       i_sck,
    input  logic       i_cs,
    input  logic       i_mosi,
    output logic       o_dout,
    input  logic [2:0] i_rd_digit,
    output logic [7:0] o_rd_data,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test,
    output logic       o_frame_valid,
    output logic [3:0] o_frame_addr,
    output logic [7:0] o_frame_data,
    output logic       o_frame_error
);

    typedef enum logic [1:0] {
        StIdle,
        StReady,
        StShift
    } state_e;

    // ------------------------------------------------------------------
    // Input synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_prev_q;
    logic                   cs_prev_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], i_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_cs};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};
            sck_prev_q  <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sck_s;
    logic cs_s;
    logic mosi_s;
    logic sck_rise;
    logic sck_fall;
    logic cs_rise;
    logic cs_fall;

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    // ------------------------------------------------------------------
    // Frame state machine
    // ------------------------------------------------------------------
    state_e      state_q, state_d;
    logic [15:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        frame_latch;
    logic        frame_short;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        frame_latch = 1'b0;
        frame_short = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Waiting here after reset discards any frame already in flight
                if (cs_s) begin
                    state_d = StReady;
                end
            end
            StReady: begin
                if (cs_fall) begin
                    state_d = StShift;
                    cnt_d   = '0;
                end
            end
            StShift: begin
                // A CS rise takes priority over an SCK rise seen in the same cycle
                if (cs_rise) begin
                    state_d = StReady;
                    if (cnt_q >= 5'd16) begin
                        frame_latch = 1'b1;
                    end else begin
                        frame_short = 1'b1;
                    end
                end else if (sck_rise) begin
                    shift_d = {shift_q[14:0], mosi_s};
                    if (cnt_q != 5'd31) begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= StIdle;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Daisy-chain output
    // ------------------------------------------------------------------
    logic dout_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            dout_q <= 1'b0;
        end else if ((state_q == StShift) && sck_fall) begin
            dout_q <= shift_q[15];
        end
    end

    assign o_dout = dout_q;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [2:0] digit_idx;

    assign wr_addr   = shift_q[11:8];
    assign wr_data   = shift_q[7:0];
    // Addresses 1..8 map to digits 0..7; address 8 wraps to index 7
    assign digit_idx = wr_addr[2:0] - 3'd1;

    logic [7:0] digit_q [8];
    logic [7:0] decode_mode_q;
    logic [3:0] intensity_q;
    logic [2:0] scan_limit_q;
    logic       shutdown_n_q;
    logic       display_test_q;
    logic       frame_valid_q;
    logic       frame_error_q;
    logic [3:0] frame_addr_q;
    logic [7:0] frame_data_q;

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            for (int i = 0; i < 8; i++) begin
                digit_q[i] <= '0;
            end
            decode_mode_q  <= '0;
            intensity_q    <= '0;
            scan_limit_q   <= '0;
            shutdown_n_q   <= 1'b0;
            display_test_q <= 1'b0;
            frame_valid_q  <= 1'b0;
            frame_error_q  <= 1'b0;
            frame_addr_q   <= '0;
            frame_data_q   <= '0;
        end else begin
            frame_valid_q <= frame_latch;
            frame_error_q <= frame_short;
            if (frame_latch) begin
                frame_addr_q <= wr_addr;
                frame_data_q <= wr_data;
                case (wr_addr)
                    4'h1, 4'h2, 4'h3, 4'h4,
                    4'h5, 4'h6, 4'h7, 4'h8: digit_q[digit_idx] <= wr_data;
                    4'h9:    decode_mode_q  <= wr_data;
                    4'hA:    intensity_q    <= wr_data[3:0];
                    4'hB:    scan_limit_q   <= wr_data[2:0];
                    4'hC:    shutdown_n_q   <= wr_data[0];
                    4'hF:    display_test_q <= wr_data[0];
                    default: ;
                endcase
            end
        end
    end

    assign o_rd_data      = digit_q[i_rd_digit];
    assign o_decode_mode  = decode_mode_q;
    assign o_intensity    = intensity_q;
    assign o_scan_limit   = scan_limit_q;
    assign o_shutdown_n   = shutdown_n_q;
    assign o_display_test = display_test_q;
    assign o_frame_valid  = frame_valid_q;
    assign o_frame_error  = frame_error_q;
    assign o_frame_addr   = frame_addr_q;
    assign o_frame_data   = frame_data_q;

endmodule

// File: tb/tb_max7219_receiver.sv
// Directed bench for max7219_receiver: table of single-frame writes plus hand-written
// sequences for short/long frames, reset mid-frame and coincident CS/SCK edges.
module tb_max7219_receiver;

    localparam int HALF = 60;   // half SCK period: 6 clk cycles (12:1 clock ratio)
    localparam int GAP  = 240;

    logic       clk = 1'b0;
    logic       res;
    logic       i_sck;
    logic       i_cs;
    logic       i_mosi;
    logic       o_dout;
    logic [2:0] i_rd_digit;
    logic [7:0] o_rd_data;
    logic [7:0] o_decode_mode;
    logic [3:0] o_intensity;
    logic [2:0] o_scan_limit;
    logic       o_shutdown_n;
    logic       o_display_test;
    logic       o_frame_valid;
    logic [3:0] o_frame_addr;
    logic [7:0] o_frame_data;
    logic       o_frame_error;

    max7219_receiver #(
        .SYNC_STAGES(2)
    ) dut (
        .clk           (clk),
        .res           (res),
        .i_sck         (i_sck),
        .i_cs          (i_cs),
        .i_mosi        (i_mosi),
        .o_dout        (o_dout),
        .i_rd_digit    (i_rd_digit),
        .o_rd_data     (o_rd_data),
        .o_decode_mode (o_decode_mode),
        .o_intensity   (o_intensity),
        .o_scan_limit  (o_scan_limit),
        .o_shutdown_n  (o_shutdown_n),
        .o_display_test(o_display_test),
        .o_frame_valid (o_frame_valid),
        .o_frame_addr  (o_frame_addr),
        .o_frame_data  (o_frame_data),
        .o_frame_error (o_frame_error)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int valid_cnt = 0;
    int error_cnt = 0;
    logic dout_log [32];

    // Count pulse-cycles so a stretched or missing pulse shows up as a wrong delta
    always @(negedge clk) begin
        if (o_frame_valid === 1'b1) valid_cnt++;
        if (o_frame_error === 1'b1) error_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic spi_begin();
        @(negedge clk);
        i_cs = 1'b0;
        #HALF;
    endtask

    // dout_log[j] holds o_dout after j completed SCK falls
    task automatic spi_bit(input logic b, input int j);
        i_mosi = b;
        #HALF;
        dout_log[j] = o_dout;
        i_sck = 1'b1;
        #HALF;
        i_sck = 1'b0;
    endtask

    task automatic spi_end();
        #HALF;
        i_cs = 1'b1;
        #GAP;
    endtask

    task automatic send_frame(input logic [31:0] bits, input int n);
        spi_begin();
        for (int k = 0; k < n; k++) begin
            spi_bit(bits[n-1-k], k);
        end
        spi_end();
    endtask

    task automatic read_digit(input logic [2:0] d, output logic [7:0] v);
        i_rd_digit = d;
        #1;
        v = o_rd_data;
    endtask

    function automatic logic [7:0] sel_out(input int sel);
        case (sel)
            0:       return o_rd_data;
            1:       return {7'd0, o_shutdown_n};
            2:       return {4'd0, o_intensity};
            3:       return {5'd0, o_scan_limit};
            4:       return o_decode_mode;
            5:       return {7'd0, o_display_test};
            default: return 8'd0;
        endcase
    endfunction

    // sel: 0 digit[idx], 1 shutdown, 2 intensity, 3 scan limit, 4 decode, 5 test, 6 none
    typedef struct {
        logic [15:0] frame;
        int          sel;
        logic [2:0]  idx;
        logic [7:0]  exp;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];
    logic [7:0] exp_digit [8];

    initial begin
        int v0;
        int e0;
        logic [7:0] rd;
        logic [15:0] dword;

        vecs[0]  = '{16'h0356, 0, 3'd2, 8'h56};
        vecs[1]  = '{16'h0C01, 1, 3'd0, 8'h01};
        vecs[2]  = '{16'h0A3F, 2, 3'd0, 8'h0F};
        vecs[3]  = '{16'h0B05, 3, 3'd0, 8'h05};
        vecs[4]  = '{16'h09FF, 4, 3'd0, 8'hFF};
        vecs[5]  = '{16'h0F01, 5, 3'd0, 8'h01};
        vecs[6]  = '{16'h0D77, 6, 3'd0, 8'h00};
        vecs[7]  = '{16'h0000, 6, 3'd0, 8'h00};
        vecs[8]  = '{16'hF1AA, 0, 3'd0, 8'hAA};
        vecs[9]  = '{16'h0CFE, 1, 3'd0, 8'h00};
        vecs[10] = '{16'h0C03, 1, 3'd0, 8'h01};
        vecs[11] = '{16'h0B0E, 3, 3'd0, 8'h06};
        vecs[12] = '{16'h0A20, 2, 3'd0, 8'h00};
        vecs[13] = '{16'h0868, 0, 3'd7, 8'h68};
        for (int d = 0; d < 8; d++) exp_digit[d] = 8'h00;
        exp_digit[0] = 8'hAA;
        exp_digit[2] = 8'h56;
        exp_digit[7] = 8'h68;

        // Reset defaults
        res = 1'b1;
        i_cs = 1'b1;
        i_sck = 1'b0;
        i_mosi = 1'b0;
        i_rd_digit = 3'd0;
        repeat (3) @(negedge clk);
        check("rst_dout", 32'(o_dout), 32'd0);
        check("rst_decode", 32'(o_decode_mode), 32'd0);
        check("rst_intensity", 32'(o_intensity), 32'd0);
        check("rst_scan", 32'(o_scan_limit), 32'd0);
        check("rst_shutdown_n", 32'(o_shutdown_n), 32'd0);
        check("rst_test", 32'(o_display_test), 32'd0);
        check("rst_valid", 32'(o_frame_valid), 32'd0);
        check("rst_error", 32'(o_frame_error), 32'd0);
        check("rst_addr", 32'(o_frame_addr), 32'd0);
        check("rst_data", 32'(o_frame_data), 32'd0);
        for (int d = 0; d < 8; d++) begin
            read_digit(3'(d), rd);
            check($sformatf("rst_digit%0d", d), 32'(rd), 32'd0);
        end
        @(negedge clk);
        res = 1'b0;
        repeat (10) @(negedge clk);

        // Table of single frames
        for (int i = 0; i < NVEC; i++) begin
            v0 = valid_cnt;
            send_frame(32'(vecs[i].frame), 16);
            check($sformatf("vec%0d_valid", i), 32'(valid_cnt - v0), 32'd1);
            check($sformatf("vec%0d_addr", i), 32'(o_frame_addr), 32'(vecs[i].frame[11:8]));
            check($sformatf("vec%0d_data", i), 32'(o_frame_data), 32'(vecs[i].frame[7:0]));
            i_rd_digit = vecs[i].idx;
            #1;
            if (vecs[i].sel != 6) begin
                check($sformatf("vec%0d_reg", i), 32'(sel_out(vecs[i].sel)), 32'(vecs[i].exp));
            end
        end

        for (int d = 0; d < 8; d++) begin
            read_digit(3'(d), rd);
            check($sformatf("sweep_digit%0d", d), 32'(rd), 32'(exp_digit[d]));
        end
        check("final_decode", 32'(o_decode_mode), 32'hFF);
        check("final_test", 32'(o_display_test), 32'd1);

        // Short frame: 12 bits
        v0 = valid_cnt;
        e0 = error_cnt;
        send_frame(32'h0000_0399, 12);
        check("short_error", 32'(error_cnt - e0), 32'd1);
        check("short_valid", 32'(valid_cnt - v0), 32'd0);
        read_digit(3'd2, rd);
        check("short_digit2", 32'(rd), 32'h56);
        check("short_addr", 32'(o_frame_addr), 32'h8);
        check("short_data", 32'(o_frame_data), 32'h68);

        // Long frame: 32 bits, last 16 win, dout replays the first 16
        v0 = valid_cnt;
        send_frame(32'h0111_0822, 32);
        check("long_valid", 32'(valid_cnt - v0), 32'd1);
        read_digit(3'd7, rd);
        check("long_digit7", 32'(rd), 32'h22);
        read_digit(3'd0, rd);
        check("long_digit0", 32'(rd), 32'hAA);
        for (int j = 16; j < 32; j++) dword[31-j] = dout_log[j];
        check("long_dout", 32'(dword), 32'h0111);

        // CS rise coincident with the 17th SCK rise
        v0 = valid_cnt;
        e0 = error_cnt;
        spi_begin();
        for (int k = 0; k < 16; k++) spi_bit(16'h0233 >> (15 - k) & 1'b1, k);
        i_mosi = 1'b1;
        #HALF;
        i_sck = 1'b1;
        i_cs = 1'b1;
        #HALF;
        i_sck = 1'b0;
        #GAP;
        check("coinc_valid", 32'(valid_cnt - v0), 32'd1);
        check("coinc_error", 32'(error_cnt - e0), 32'd0);
        check("coinc_addr", 32'(o_frame_addr), 32'h2);
        check("coinc_data", 32'(o_frame_data), 32'h33);
        read_digit(3'd1, rd);
        check("coinc_digit1", 32'(rd), 32'h33);
        read_digit(3'd3, rd);
        check("coinc_digit3", 32'(rd), 32'h00);

        // Reset asserted during bit 8 with CS held low
        spi_begin();
        for (int k = 0; k < 7; k++) spi_bit(16'h0155 >> (15 - k) & 1'b1, k);
        i_mosi = 1'b0;
        #HALF;
        i_sck = 1'b1;
        res = 1'b1;
        #HALF;
        i_sck = 1'b0;
        #20;
        res = 1'b0;
        check("midrst_shutdown", 32'(o_shutdown_n), 32'd0);
        check("midrst_addr", 32'(o_frame_addr), 32'd0);
        v0 = valid_cnt;
        e0 = error_cnt;
        for (int k = 8; k < 16; k++) spi_bit(16'h0155 >> (15 - k) & 1'b1, k);
        spi_end();
        check("midrst_valid", 32'(valid_cnt - v0), 32'd0);
        check("midrst_error", 32'(error_cnt - e0), 32'd0);
        read_digit(3'd0, rd);
        check("midrst_digit0", 32'(rd), 32'h00);

        // Recovery after the discarded frame
        v0 = valid_cnt;
        send_frame(32'h0000_0155, 16);
        check("recover_valid", 32'(valid_cnt - v0), 32'd1);
        read_digit(3'd0, rd);
        check("recover_digit0", 32'(rd), 32'h55);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/max7219_receiver.md
# max7219_receiver

Clocked SPI responder that emulates the register interface of a MAX7219 7-segment display driver. It is the receive end of the `o_mosi`/`o_cs`/`o_sck` link driven by the stopwatch. It samples the three asynchronous SPI lines with a fast system clock and decodes 16-bit frames. It maintains the MAX7219 register file and exposes it so that an on-board FPGA display path or a bench monitor can check what the stopwatch wrote.

## Interface
Parameters:
- `SYNC_STAGES`, default 2: synchronizer depth on `i_sck`, `i_cs` and `i_mosi` (minimum 2).

Ports:
- `clk`, in, 1: system clock; must be at least 4× the SCK frequency (12 MHz board clock against a ≤1 MHz SCK).
- `res`, in, 1: reset; asynchronous, active-high.
- `i_sck`, in, 1: SPI clock, asynchronous to `clk`, idle low.
- `i_cs`, in, 1: chip select, active-low, asynchronous.
- `i_mosi`, in, 1: serial data, MSB first, asynchronous.
- `o_dout`, out, 1: daisy-chain output, the MSB of the shift register, updated on SCK falling edges.
- `i_rd_digit`, in, 3: digit index for the read port.
- `o_rd_data`, out, 8: contents of digit register `i_rd_digit`; combinational read.
- `o_decode_mode`, out, 8: register 0x9.
- `o_intensity`, out, 4: register 0xA, bits 3:0.
- `o_scan_limit`, out, 3: register 0xB, bits 2:0.
- `o_shutdown_n`, out, 1: register 0xC, bit 0. 0 means shutdown.
- `o_display_test`, out, 1: register 0xF, bit 0.
- `o_frame_valid`, out, 1: one-cycle pulse when a frame has been latched.
- `o_frame_addr`, out, 4: address field of the last latched frame.
- `o_frame_data`, out, 8: data field of the last latched frame.
- `o_frame_error`, out, 1: one-cycle pulse when CS rises with fewer than 16 bits received.

## Operation
- **Synchronizers:** each input passes through `SYNC_STAGES` flops. SCK and CS edges are detected from the last two synchronized samples.
- **State machine:**
  - IDLE: entered on reset. Go to READY when synchronized CS = 1.
  - READY: go to SHIFT on a CS falling edge.
  - SHIFT: on each SCK rising edge, shift the synchronized MOSI into the 16-bit shift register LSB, and increment the 5-bit bit counter (saturates at 31). On a CS rising edge, go to READY.
- **Counter reset:** the bit counter clears on entry to SHIFT.
- **Latch on CS rise:**
  - If count ≥ 16, take the last 16 bits received (bits 15:12 are don't care, 11:8 are the address, 7:0 the data). Write the addressed register and pulse `o_frame_valid`.
  - If count < 16, write nothing and pulse `o_frame_error`.
- **Address map:**
  - 0x0: no-op. `o_frame_valid` still pulses.
  - 0x1–0x8: digit 0–7.
  - 0x9: decode mode.
  - 0xA: intensity.
  - 0xB: scan limit.
  - 0xC: shutdown.
  - 0xF: display test.
  - 0xD, 0xE: ignored; `o_frame_valid` still pulses.
- **Narrow registers:** write only the low bits listed under Interface; upper data bits are discarded.
- **`o_dout`:** on each SCK falling edge while in SHIFT, `o_dout` takes `shift[15]`. It holds when CS is high.
- **Reset values:** all registers 0, so the device starts in shutdown with test off. `o_dout`, `o_frame_valid` and `o_frame_error` are 0. `o_frame_addr` and `o_frame_data` are 0, and the shift register and counter are 0. State is IDLE.

## Timing
- **Input latency:** a pin edge becomes a detected edge `SYNC_STAGES`+1 `clk` cycles later.
- **Frame latency:** registers and `o_frame_*` update, and the pulse asserts, in the cycle after the CS rising edge is detected. Registers hold until the next write.
- **Simultaneous edges:** if an SCK rise and a CS rise are detected in the same cycle, the CS rise wins and that SCK edge is not shifted.
- **SCK with CS high:** ignored.
- **MOSI hold:** MOSI must be stable for at least `SYNC_STAGES`+1 cycles around each SCK rise.
- **Reset mid-frame:** registers clear and the partial frame is discarded. If CS is still low on reset release, the remainder of that frame is ignored until CS goes high (IDLE).
- **Back-to-back frames:** allowed with CS high for at least 2 detected cycles.

## Test plan
- **Reset defaults:** assert `res`. Require all outputs to be 0, and `o_rd_data` = 0 for every digit.
- **Digit write:** frame 0x0356 (addr 3, data 0x56) at SCK = 1 MHz, `clk` = 12 MHz. Require `o_frame_valid` 1 cycle, `o_frame_addr` = 3, `o_frame_data` = 0x56, and `o_rd_data` = 0x56 with `i_rd_digit` = 2.
- **Control registers:**
  - Frames 0x0C01, 0x0A3F, 0x0B05, 0x09FF, 0x0F01.
  - Require `o_shutdown_n` = 1, `o_intensity` = 0xF, `o_scan_limit` = 5, `o_decode_mode` = 0xFF, `o_display_test` = 1.
- **Short frame:** 12 bits, then CS rises. Require `o_frame_error` pulse, no `o_frame_valid`, registers unchanged.
- **Long frame:** 32 bits 0x0111_0822. Require digit 7 = 0x22 and digit 0 unchanged. `o_dout` must replay the first 16 bits (0x0111) delayed by 16 SCK falls.
- **Edge cases:**
  - Assert `res` during bit 8 with CS held low, then release. Require no write until CS goes high.
  - CS rise coincident with the 17th SCK rise. Require the first 16 bits to be latched.
